// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the PC, prefetches imem words into a
// DEPTH-entry circular queue and hands {pc, instr} to decode over valid/ready.
module fetch_queue #(
  parameter int               XLEN     = 32,
  parameter int               DEPTH    = 4,
  parameter logic [XLEN-1:0]  RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_data,
  input  logic            imem_rdy,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr_data,
  output logic [XLEN-1:0] instr_pc,
  input  logic            instr_ready,
  output logic            fetch_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [XLEN-1:0] pc;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [XLEN-1:0] q_pc   [DEPTH];
  logic [XLEN-1:0] q_data [DEPTH];
  logic            full;
  logic            pop;
  logic            push;

  assign imem_addr   = pc;
  assign full        = (count == CW'(DEPTH));
  assign instr_valid = (count != '0);
  assign instr_data  = instr_valid ? q_data[rd_ptr] : '0;
  assign instr_pc    = instr_valid ? q_pc[rd_ptr]   : '0;

  // A redirect kills both sides of the handshake; a full queue still
  // accepts a word when the head leaves in the same cycle.
  assign pop  = instr_valid & instr_ready & ~redirect_valid;
  assign push = imem_rdy & ~redirect_valid & (~full | pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc        <= RESET_PC;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      fetch_err <= 1'b0;
    end else if (redirect_valid) begin
      pc        <= {redirect_pc[XLEN-1:2], 2'b00};
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      fetch_err <= |redirect_pc[1:0];
    end else begin
      fetch_err <= 1'b0;
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
        pc     <= pc + XLEN'(4);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible through count.
  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[wr_ptr]   <= pc;
      q_data[wr_ptr] <= imem_data;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed plus randomized bench for fetch_queue against a queue-based
// reference model of the fetch/decode stream.
module tb_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        imem_rdy;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        fetch_err;

  int checks_total  = 0;
  int checks_passed = 0;

  // Reference model: entries are {pc, data}
  logic [63:0] mq[$];
  logic [31:0] mpc;
  logic        merr;

  fetch_queue #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .imem_rdy       (imem_rdy),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready),
    .fetch_err      (fetch_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
  endfunction

  assign imem_data = mem_word(imem_addr);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_total++;
    assert (obs === exp) checks_passed++;
    else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic model_reset();
    mq.delete();
    mpc  = RESET_PC;
    merr = 1'b0;
  endtask

  // One clock cycle: drive inputs, compare outputs against the model, advance.
  task automatic step(input logic rdy, input logic rdyd, input logic redir,
                      input logic [31:0] rpc);
    logic        ev;
    logic        do_pop;
    logic        do_push;
    logic [31:0] ep;
    logic [31:0] ed;
    imem_rdy       = rdy;
    instr_ready    = rdyd;
    redirect_valid = redir;
    redirect_pc    = rpc;
    #1;
    ev = (mq.size() != 0);
    ep = ev ? mq[0][63:32] : 32'h0;
    ed = ev ? mq[0][31:0]  : 32'h0;
    check("instr_valid", {31'b0, instr_valid}, {31'b0, ev});
    check("instr_pc",    instr_pc,  ep);
    check("instr_data",  instr_data, ed);
    check("imem_addr",   imem_addr, mpc);
    check("fetch_err",   {31'b0, fetch_err}, {31'b0, merr});
    do_pop  = ev && rdyd && !redir;
    do_push = rdy && !redir && ((mq.size() < DEPTH) || do_pop);
    if (redir) begin
      mq.delete();
      mpc  = {rpc[31:2], 2'b00};
      merr = (rpc[1:0] != 2'b00);
    end else begin
      merr = 1'b0;
      if (do_pop)  void'(mq.pop_front());
      if (do_push) begin
        mq.push_back({mpc, mem_word(mpc)});
        mpc = mpc + 32'd4;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset          = 1'b1;
    imem_rdy       = 1'b0;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid", {31'b0, instr_valid}, 32'h0);
    check("reset_addr",  imem_addr, RESET_PC);
    check("reset_err",   {31'b0, fetch_err}, 32'h0);
    reset = 1'b0;

    // Free-running fetch from reset
    $display("[TB] free-run from reset");
    step(1'b1, 1'b1, 1'b0, 32'h0);
    check("t1_first_pc", instr_pc, 32'h100);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    check("t1_second_pc", instr_pc, 32'h104);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    check("t1_third_pc", instr_pc, 32'h108);

    // Decode backpressure fills the queue, then drains with no gap
    $display("[TB] backpressure");
    redirect_valid = 1'b0;
    step(1'b0, 1'b1, 1'b1, 32'h100);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
    check("t2_addr_hold", imem_addr, 32'h110);
    check("t2_head_hold", instr_pc, 32'h100);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 32'h0);

    // Redirect from a full queue with decode ready
    $display("[TB] redirect from full queue");
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b1, 32'h2000);
    check("t3_flush_valid", {31'b0, instr_valid}, 32'h0);
    check("t3_flush_addr",  imem_addr, 32'h2000);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    check("t3_head_pc", instr_pc, 32'h2000);

    // imem stalls
    $display("[TB] imem stall pattern");
    step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0);

    // PC wraparound
    $display("[TB] pc wraparound");
    step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    check("t5_pc_fff8", instr_pc, 32'hFFFF_FFF8);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    check("t5_pc_fffc", instr_pc, 32'hFFFF_FFFC);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    check("t5_pc_0000", instr_pc, 32'h0000_0000);

    // Misaligned redirect, back-to-back redirects
    $display("[TB] misaligned and back-to-back redirects");
    step(1'b1, 1'b1, 1'b1, 32'h3002);
    check("t6_err_pulse", {31'b0, fetch_err}, 32'h1);
    check("t6_aligned",   imem_addr, 32'h3000);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    check("t6_err_clear", {31'b0, fetch_err}, 32'h0);
    check("t6_head_pc",   instr_pc, 32'h3000);
    step(1'b1, 1'b1, 1'b1, 32'h4000);
    step(1'b1, 1'b1, 1'b1, 32'h5001);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    check("t6_last_wins", instr_pc, 32'h5000);

    // Randomized traffic
    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      logic        r;
      logic        d;
      logic        rv;
      logic [31:0] rp;
      r  = ($urandom % 4) != 0;
      d  = ($urandom % 3) != 0;
      rv = ($urandom % 20) == 0;
      rp = $urandom & 32'h0000_FFFF;
      step(r, d, rv, rp);
    end

    // Asynchronous reset mid-stream
    $display("[TB] async reset mid-stream");
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
    reset = 1'b1;
    #1;
    check("async_rst_valid", {31'b0, instr_valid}, 32'h0);
    check("async_rst_addr",  imem_addr, RESET_PC);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 32'h0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
